// File: rtl/flash_read_arbiter_pkg.sv
// Shared constants and types for the two-port SPI flash read arbiter.
// Frame layout is {READ, addr, dummy-byte} shifted MSB first.
package FLASH_ARB_PKG;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         FRAME_BITS = 40;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    ACK,
    GAP
  } state_t;

  function automatic logic [FRAME_BITS-1:0] read_frame(
    input logic [23:0] addr
  );
    return {CMD_READ, addr, 8'h00};
  endfunction

endpackage

// File: rtl/flash_read_arbiter_if.sv
// Requester-side bus of the flash read arbiter: level requests,
// per-port byte addresses, one-cycle ACK pulses and the read byte.
interface flash_read_arbiter_if;

  logic [1:0]  REQ;
  logic [23:0] ADDR0;
  logic [23:0] ADDR1;
  logic [1:0]  ACK;
  logic [7:0]  RDATA;

  modport master (
    output REQ,
    output ADDR0,
    output ADDR1,
    input  ACK,
    input  RDATA
  );

  modport slave (
    input  REQ,
    input  ADDR0,
    input  ADDR1,
    output ACK,
    output RDATA
  );

endinterface

// File: rtl/flash_spi_shifter.sv
// SPI mode-0 frame engine: SCK divider, 40-bit MOSI shifter,
// bit counter and an 8-bit MISO capture of the last samples.
module flash_spi_shifter
  import FLASH_ARB_PKG::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  sck,
  output logic                  mosi,
  output logic                  done,
  output logic [7:0]            rx
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);

  logic                  active;
  logic [DW-1:0]         div;
  logic [5:0]            bits;
  logic [FRAME_BITS-1:0] sr;

  assign mosi = sr[FRAME_BITS-1];

  // Asserted on the cycle whose edge ends the final SCK high phase.
  assign done = active & sck
              & (div == DIV_LAST)
              & (bits == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      div    <= '0;
      bits   <= '0;
      sr     <= '0;
      sck    <= 1'b0;
      rx     <= '0;
    end else if (start) begin
      active <= 1'b1;
      div    <= '0;
      bits   <= '0;
      sr     <= frame;
      sck    <= 1'b0;
    end else if (active) begin
      if (div == DIV_LAST) begin
        div <= '0;
        sck <= ~sck;
        if (!sck) begin
          rx <= {rx[6:0], miso};
        end else begin
          sr   <= sr << 1;
          bits <= bits + 1'b1;
          if (bits == BIT_LAST) active <= 1'b0;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin two-port arbiter sequencing one SPI READ byte per grant
// on the shared configuration flash.
module flash_read_arbiter
  import FLASH_ARB_PKG::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  flash_read_arbiter_if.slave  bus,
  output logic                 FLASH_CS_n,
  output logic                 FLASH_SCK,
  output logic                 FLASH_MOSI,
  input  logic                 FLASH_MISO
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rr_last;
  logic          gnt;
  logic          pick;
  logic [23:0]   addr_q;
  logic [1:0]    ack_q;
  logic [7:0]    rdata_q;
  logic          start;
  logic          done;
  logic [7:0]    rx;
  logic          cnt_end;

  assign bus.ACK   = ack_q;
  assign bus.RDATA = rdata_q;

  // On contention the port that did not win last time goes next.
  assign pick = (&bus.REQ) ? ~rr_last : bus.REQ[1];

  assign cnt_end = (cnt == CNT_LAST);
  assign start   = (state == SETUP) && cnt_end;

  flash_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (CLK),
    .rst   (RESET),
    .start (start),
    .frame (read_frame(addr_q)),
    .miso  (FLASH_MISO),
    .sck   (FLASH_SCK),
    .mosi  (FLASH_MOSI),
    .done  (done),
    .rx    (rx)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_last    <= 1'b1;
      gnt        <= 1'b0;
      addr_q     <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      FLASH_CS_n <= 1'b1;
    end else begin
      ack_q <= '0;
      unique case (state)
        IDLE: begin
          if (|bus.REQ) begin
            gnt        <= pick;
            rr_last    <= pick;
            addr_q     <= pick ? bus.ADDR1 : bus.ADDR0;
            FLASH_CS_n <= 1'b0;
            cnt        <= '0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_end) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (done) state <= HOLD;
        end
        HOLD: begin
          if (cnt_end) begin
            cnt        <= '0;
            ack_q      <= gnt ? 2'b10 : 2'b01;
            rdata_q    <= rx;
            FLASH_CS_n <= 1'b1;
            state      <= ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          state <= GAP;
        end
        GAP: begin
          if (cnt_end) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/flash_read_arbiter.md
# flash_read_arbiter

Shares the board's single SPI configuration flash between two read requesters and sequences each access as a standard SPI READ (0x03) transaction. Port 0 is the cartridge ROM fetch path; port 1 is the background loader (TF/config shadowing). Arbitration is round-robin, one byte per grant. SCK is derived from the system clock by the board-level flash clock divide ratio (FLASH_CLK_DIV in the board configuration package).

## Interface
- `CLK_DIV`, default 2: SCK half-period in `CLK` cycles; legal range ≥1; instantiated with the board's FLASH_CLK_DIV.
- `CLK`  in  1  system clock; all logic is in this one domain.
- `RESET`  in  1  asynchronous, active-high reset.
- `REQ[1:0]`  in  2  per-port read request (level).
- `ADDR0`, `ADDR1`  in  24 each  byte address; held stable while the matching `REQ` is high.
- `ACK[1:0]`  out  2  one-cycle pulse per port; read data valid in the same cycle.
- `RDATA`  out  8  byte from the last completed transaction; holds until the next ACK.
- `FLASH_CS_n`  out  1  chip select, active low.
- `FLASH_SCK`  out  1  SPI clock, mode 0 (idles low).
- `FLASH_MOSI`  out  1  serial command/address out.
- `FLASH_MISO`  in  1  serial data in; synchronous to SCK.

## Operation
- Reset values: `ACK`=0, `RDATA`=0x00, `FLASH_CS_n`=1, `FLASH_SCK`=0, `FLASH_MOSI`=0, state=IDLE, round-robin pointer favours port 0.
- FSM states:
  - IDLE: if any `REQ` is high, grant and latch the address → SETUP.
  - SETUP: `CS_n` low, SCK low for `CLK_DIV` cycles → SHIFT.
  - SHIFT: 40 SCK periods → HOLD.
  - HOLD: SCK low for `CLK_DIV` cycles → ACK state.
  - ACK state: `CS_n`=1, pulse `ACK[g]`, update `RDATA` → GAP.
  - GAP: `CS_n` high for `CLK_DIV` cycles → IDLE.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not granted last wins.
  - After reset, port 0 is treated as higher priority.
- Shift frame: 40-bit word {0x03, addr[23:0], 8'h00}, MSB first.
  - `MOSI` updates at the start of each SCK low phase.
  - `MISO` is sampled in the cycle SCK rises. The last 8 samples form `RDATA`.
  - `MOSI` is driven 0 during the data byte.
- `REQ` and `ADDR` are sampled only in IDLE.
  - Once granted, the transaction completes and ACK pulses even if `REQ` drops.
  - A requester must deassert `REQ` in the cycle after ACK, or it is granted again.
- No reads are issued while `REQ`=0; no write or erase commands are supported.

## Timing
- T0 = IDLE cycle with `REQ` sampled high.
  - `CS_n` falls at T0+1.
  - First SCK rise at T0+1+2·`CLK_DIV`.
  - `ACK` at T0+1+82·`CLK_DIV`; with `CLK_DIV`=2 that is T0+165.
- SCK period is 2·`CLK_DIV`, 50% duty. Exactly 40 rising edges per frame.
- `CS_n` minimum high time between frames is `CLK_DIV`+1 cycles (ACK cycle plus GAP).
- Reset mid-frame: outputs return to reset values asynchronously and the in-flight request gets no ACK. After reset release, arbitration restarts with port 0 favoured.
- Divider counter width is $clog2(`CLK_DIV`+1); the 40-bit counter is 6 bits. No wrap is visible outside SHIFT.

## Structure
- Shared package `FLASH_ARB_PKG`:
  - `CMD_READ` = 8'h03
  - `FRAME_BITS` = 40
  - state enum {IDLE, SETUP, SHIFT, HOLD, ACK, GAP}
- Natural sub-module `flash_spi_shifter`: SCK divider, 40-bit shift register and bit counter, with start/done handshake. The top level holds the arbiter, FSM and output registers.

## Test plan
- Port 0 alone, `ADDR0`=0x012345, flash model returns 0xA5, `CLK_DIV`=2 → MOSI stream 03 01 23 45; `ACK[0]` at T0+165; `RDATA`=0xA5; 40 SCK rises.
- Both `REQ` rise together after reset, `ADDR0`=0x000010, `ADDR1`=0x000020 → port 0 served first, then port 1. `CS_n` stays high for ≥3 cycles between frames.
- Port 1 served alone, then both request → port 0 granted next. Port 1 is granted next if both are still asserted.
- `RESET` pulsed at frame bit 20 → `CS_n`=1 and SCK=0 immediately; no ACK. The next request runs a complete 40-bit frame.
- `CLK_DIV`=1 build, `ADDR1`=0xFFFFFF, model returns 0x3C → `ACK[1]` at T0+83; `RDATA`=0x3C; SCK period 2 cycles.
- `REQ[0]` dropped one cycle after grant → transaction completes, `ACK[0]` pulses, no second frame starts.
